// File: rtl/uart_tx_dev.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_dev
// Brief    : Bus-mapped 8N1 UART transmitter with TX FIFO, programmable baud
//            divisor and TX-empty level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_dev #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_result,
    output logic        irq,
    output logic        uart_txd
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    localparam logic [1:0] c_A_DATA   = 2'd0;
    localparam logic [1:0] c_A_STATUS = 2'd1;
    localparam logic [1:0] c_A_CTRL   = 2'd2;
    localparam logic [1:0] c_A_DIV    = 2'd3;

    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overrun;
    logic               r_irq_en;
    logic [15:0]        r_div;
    logic [15:0]        r_cur_div;
    logic [15:0]        r_baud_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [1:0]         r_state;
    logic               r_txd;
    logic               r_irq;

    logic               w_full;
    logic               w_empty;
    logic               w_data_wr;
    logic               w_push;
    logic               w_pop;
    logic               w_baud_done;
    logic [1:0]         w_state_next;
    logic [15:0]        w_baud_next;
    logic [2:0]         w_bit_next;
    logic [7:0]         w_shift_next;
    logic [15:0]        w_cur_div_next;
    logic [c_CNT_W-1:0] w_count_next;
    logic               w_irq_en_next;
    logic               w_txd_next;
    logic [3:0]         w_cnt4;
    logic               w_unused_ok;

    assign w_full      = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_data_wr   = write_enable && (addr == c_A_DATA);
    // A store into a full FIFO is dropped even if the FSM pops on this edge.
    assign w_push      = w_data_wr && !w_full;
    assign w_baud_done = (r_baud_cnt == r_cur_div - 16'd1);
    assign w_cnt4      = 4'(r_count);
    assign w_unused_ok = ^write_data[31:16];

    always_comb begin
        w_state_next   = r_state;
        w_pop          = 1'b0;
        w_baud_next    = r_baud_cnt + 16'd1;
        w_bit_next     = r_bit_cnt;
        w_shift_next   = r_shift;
        w_cur_div_next = r_cur_div;
        case (r_state)
            c_S_IDLE: begin
                w_baud_next = 16'd0;
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = r_fifo[r_rd_ptr];
                    w_cur_div_next = r_div;
                    w_state_next   = c_S_START;
                end
            end
            c_S_START: begin
                if (w_baud_done) begin
                    w_baud_next  = 16'd0;
                    w_bit_next   = 3'd0;
                    w_state_next = c_S_DATA;
                end
            end
            c_S_DATA: begin
                if (w_baud_done) begin
                    w_baud_next  = 16'd0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = c_S_STOP;
                    end else begin
                        w_bit_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                if (w_baud_done) begin
                    w_baud_next = 16'd0;
                    if (!w_empty) begin
                        w_pop          = 1'b1;
                        w_shift_next   = r_fifo[r_rd_ptr];
                        w_cur_div_next = r_div;
                        w_state_next   = c_S_START;
                    end else begin
                        w_state_next = c_S_IDLE;
                    end
                end
            end
        endcase

        case (w_state_next)
            c_S_START: w_txd_next = 1'b0;
            c_S_DATA:  w_txd_next = w_shift_next[0];
            default:   w_txd_next = 1'b1;
        endcase

        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_W'(1);
            2'b01:   w_count_next = r_count - c_CNT_W'(1);
            default: w_count_next = r_count;
        endcase

        w_irq_en_next = (write_enable && addr == c_A_CTRL) ? write_data[0] : r_irq_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overrun  <= 1'b0;
            r_irq_en   <= 1'b0;
            r_div      <= 16'(DEFAULT_DIV);
            r_cur_div  <= 16'(DEFAULT_DIV);
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_txd      <= 1'b1;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_cur_div  <= w_cur_div_next;
            r_txd      <= w_txd_next;
            r_irq_en   <= w_irq_en_next;
            r_irq      <= w_irq_en_next && (w_count_next == '0) && (w_state_next == c_S_IDLE);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_data_wr && w_full) begin
                r_overrun <= 1'b1;
            end else if (write_enable && addr == c_A_STATUS) begin
                r_overrun <= 1'b0;
            end
            if (write_enable && addr == c_A_DIV) begin
                r_div <= (write_data[15:0] == 16'd0) ? 16'd1 : write_data[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= write_data[7:0];
        end
    end

    always_comb begin
        case (addr)
            c_A_STATUS: read_result = {24'd0, w_cnt4, r_overrun, w_empty, w_full,
                                       (r_state != c_S_IDLE)};
            c_A_CTRL:   read_result = {31'd0, r_irq_en};
            c_A_DIV:    read_result = {16'd0, r_div};
            default:    read_result = 32'd0;
        endcase
    end

    assign uart_txd = r_txd;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_dev.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_dev
// Brief    : Self-checking bench for uart_tx_dev against a serial-waveform model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_dev;

    localparam int c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  addr = 2'd1;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_result;
    logic        irq;
    logic        uart_txd;

    always #5 clk = ~clk;

    uart_tx_dev #(.FIFO_DEPTH(c_DEPTH), .DEFAULT_DIV(2604)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_result  (read_result),
        .irq          (irq),
        .uart_txd     (uart_txd)
    );

    // Expected line level per clock; 'first' marks the start-bit cycle where the FIFO pops.
    typedef struct {
        logic v;
        bit   first;
    } sym_t;

    typedef struct {
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    sym_t exp_q[$];
    int   pending;
    int   m_div;
    bit   m_overrun;
    bit   m_irq_en;
    bit   m_busy;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        pending   = 0;
        m_div     = 2604;
        m_overrun = 1'b0;
        m_irq_en  = 1'b0;
        m_busy    = 1'b0;
    endfunction

    function automatic void add_frame(input logic [7:0] b);
        logic [9:0] bits;
        sym_t       s;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < m_div; k++) begin
                s.v     = bits[i];
                s.first = (i == 0 && k == 0);
                exp_q.push_back(s);
            end
        end
        pending++;
    endfunction

    function automatic logic [31:0] exp_status();
        return {24'd0, 4'(pending), m_overrun, (pending == 0), (pending == c_DEPTH), m_busy};
    endfunction

    task automatic tick();
        bit   acc;
        logic expv;
        sym_t s;
        @(posedge clk);
        #1;
        acc    = (pending < c_DEPTH);
        expv   = 1'b1;
        m_busy = 1'b0;
        if (rst) begin
            model_reset();
        end else if (exp_q.size() > 0) begin
            s      = exp_q.pop_front();
            expv   = s.v;
            m_busy = 1'b1;
            if (s.first) pending--;
        end
        chk("txd", uart_txd, expv);
        if (!rst && write_enable) begin
            case (addr)
                2'd0: if (acc) add_frame(write_data[7:0]); else m_overrun = 1'b1;
                2'd1: m_overrun = 1'b0;
                2'd2: m_irq_en = write_data[0];
                default: m_div = (write_data[15:0] == 16'd0) ? 1 : int'(write_data[15:0]);
            endcase
        end
        chk("irq", irq, m_irq_en && pending == 0 && !m_busy);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        write_data = d;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        addr = 2'd1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        chk(name, read_result, exp);
        addr = 2'd1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            tick();
            rd(2'd1, exp_status(), "status");
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            if (exp_q.size() == 0 && !m_busy) begin
                done = 1'b1;
                break;
            end
            step(1);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: model queue still holds %0d cycles", exp_q.size());
        end
    endtask

    task automatic busy_run(output int n);
        bit done = 1'b0;
        n = 0;
        for (int k = 0; k < 20000; k++) begin
            tick();
            rd(2'd1, exp_status(), "status");
            if (read_result[0]) begin
                n++;
            end else begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy never dropped after %0d cycles", n);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   n;

        vt[0] = '{2'd3, 32'h0000_0000, 32'h0000_0001};
        vt[1] = '{2'd3, 32'h0001_2345, 32'h0000_2345};
        vt[2] = '{2'd3, 32'hFFFF_0007, 32'h0000_0007};
        vt[3] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0001};
        vt[4] = '{2'd2, 32'hFFFF_FFFE, 32'h0000_0000};
        vt[5] = '{2'd0, 32'h0000_01C3, 32'h0000_0000};

        // Reset state
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rd(2'd3, 32'd2604, "reset_div");
        rd(2'd1, 32'h04, "reset_status");
        chk("reset_txd", uart_txd, 1'b1);
        chk("reset_irq", irq, 1'b0);

        // Register read/write vectors
        for (int i = 0; i < 6; i++) begin
            wr(vt[i].a, vt[i].d);
            rd(vt[i].a, vt[i].exp, "reg_rw");
        end
        drain();
        step(2);

        // Single frame 0xA5 at 4 cycles per bit
        wr(2'd3, 32'd4);
        wr(2'd0, 32'hA5);
        chk("txd_before_pop", uart_txd, 1'b1);
        busy_run(n);
        chk("busy_cycles_a5", n, 40);
        step(3);

        // Three back-to-back frames; busy already high during the 2nd and 3rd stores
        wr(2'd3, 32'd2);
        wr(2'd0, 32'h11);
        wr(2'd0, 32'h22);
        wr(2'd0, 32'h33);
        rd(2'd1, 32'h21, "count_after_b2b");
        busy_run(n);
        chk("busy_cycles_b2b", n, 58);
        step(3);

        // Overrun: one frame in flight plus four queued, the sixth store is dropped
        for (int i = 0; i < 6; i++) wr(2'd0, 32'h40 + i);
        rd(2'd1, 32'h4B, "status_overrun");
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, 32'h43, "status_ovr_cleared");
        drain();
        step(3);

        // TX-empty interrupt
        wr(2'd2, 32'd1);
        chk("irq_enabled_idle", irq, 1'b1);
        wr(2'd0, 32'h5A);
        chk("irq_after_push", irq, 1'b0);
        busy_run(n);
        chk("irq_after_stop", irq, 1'b1);
        chk("busy_cycles_irq", n, 20);
        wr(2'd2, 32'd0);
        chk("irq_disabled", irq, 1'b0);
        step(2);

        // Randomised traffic against the model
        for (int it = 0; it < 10; it++) begin
            wr(2'd3, 32'($urandom_range(0, 5)));
            if ($urandom_range(0, 1) == 1) wr(2'd2, 32'($urandom_range(0, 1)));
            n = $urandom_range(1, 7);
            for (int j = 0; j < n; j++) begin
                wr(2'd0, $urandom);
                step($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) wr(2'd1, 32'd0);
            end
            drain();
            step($urandom_range(0, 3));
        end
        wr(2'd2, 32'd0);

        // Reset in the middle of data bit 3 with two bytes queued
        wr(2'd3, 32'd4);
        wr(2'd0, 32'hC3);
        wr(2'd0, 32'h3C);
        wr(2'd0, 32'h99);
        step(16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(2'd1, 32'h04, "status_after_rst");
        rd(2'd3, 32'd2604, "div_after_rst");
        step(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
